// File: rtl/arbitro_compuertas_pkg.sv
// compuertas_pkg: FSM states and gate select codes shared by arbitro_compuertas.
// Optional error reporting is enabled by ARBITRO_COMPUERTAS_ERR_EN.
package compuertas_pkg;
  typedef enum logic [1:0] {LIBRE, EVAL, RESP} estado_t;
  localparam logic [2:0] SEL_INV0 = 3'b000;
  localparam logic [2:0] SEL_AND  = 3'b001;
  localparam logic [2:0] SEL_OR   = 3'b010;
  localparam logic [2:0] SEL_XOR  = 3'b011;
  localparam logic [2:0] SEL_NAND = 3'b100;
  localparam logic [2:0] SEL_NOR  = 3'b101;
  localparam logic [2:0] SEL_XNOR = 3'b110;
  localparam logic [2:0] SEL_INV7 = 3'b111;
  function automatic logic sel_invalido(input logic [2:0] s);
    return s == SEL_INV0 || s == SEL_INV7;
  endfunction
endpackage

// File: rtl/arbitro_compuertas_if.sv
// arbitro_compuertas_if: requester-side bus of the gate arbiter.
// The err signal exists only with ARBITRO_COMPUERTAS_ERR_EN.
interface arbitro_compuertas_if #(parameter int N = 4, parameter int CNT_W = 8);
  logic [N-1:0]     req;
  logic [N-1:0]     ack;
  logic [3*N-1:0]   ent;
  logic [3*N-1:0]   sel;
  logic             sal;
  logic             ocupado;
  logic [CNT_W-1:0] cuenta;
`ifdef ARBITRO_COMPUERTAS_ERR_EN
  logic             err;
  modport master (output req, ent, sel, input ack, sal, ocupado, cuenta, err);
  modport slave  (input req, ent, sel, output ack, sal, ocupado, cuenta, err);
`else
  modport master (output req, ent, sel, input ack, sal, ocupado, cuenta);
  modport slave  (input req, ent, sel, output ack, sal, ocupado, cuenta);
`endif
endinterface

// File: rtl/arbitro_compuertas_gates.sv
// compuertasLogicas: shared 3-input gate evaluator; output forced low when inactive.
module compuertasLogicas
  import compuertas_pkg::*;
(
  input  logic       act_i,
  input  logic [2:0] ent_i,
  input  logic [2:0] sel_i,
  output logic       sal_o
);
  always_comb begin
    sal_o = 1'b0;
    if (act_i)
      case (sel_i)
        SEL_AND:  sal_o = &ent_i;
        SEL_OR:   sal_o = |ent_i;
        SEL_XOR:  sal_o = ^ent_i;
        SEL_NAND: sal_o = ~&ent_i;
        SEL_NOR:  sal_o = ~|ent_i;
        SEL_XNOR: sal_o = ~^ent_i;
        default:  sal_o = 1'b0;
      endcase
  end
endmodule

// File: rtl/arbitro_compuertas_rr.sv
// rr_selector: combinational round-robin picker, first set request at or above ptr.
module rr_selector #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  always_comb begin
    idx_o = '0;
    // Walk downward so the candidate closest to ptr is assigned last and wins
    for (int i = N - 1; i >= 0; i--) begin
      logic [IW-1:0] j;
      j = IW'((int'(ptr_i) + i) % N);
      if (req_i[j]) idx_o = j;
    end
    gnt_o = |req_i ? N'(1) << idx_o : '0;
  end
endmodule

// File: rtl/arbitro_compuertas.sv
// arbitro_compuertas: round-robin sequencer sharing one gate evaluator among N requesters.
// ARBITRO_COMPUERTAS_ERR_EN adds err and stops invalid selects from being counted.
module arbitro_compuertas
  import compuertas_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  arbitro_compuertas_if.slave bus
);
  localparam int IW = $clog2(N);
  estado_t          st_q;
  logic [IW-1:0]    ptr_q, idx_q, idx_w;
  logic [N-1:0]     gnt_q, gnt_w, ack_q;
  logic [2:0]       ent_q, sel_q;
  logic             res_q, sal_q, gate_w;
  logic [CNT_W-1:0] cuenta_q;
`ifdef ARBITRO_COMPUERTAS_ERR_EN
  logic             err_q;
  assign bus.err = err_q;
`endif
  rr_selector #(.N(N)) u_rr (.req_i(bus.req), .ptr_i(ptr_q), .gnt_o(gnt_w), .idx_o(idx_w));
  compuertasLogicas u_gate (.act_i(st_q == EVAL), .ent_i(ent_q), .sel_i(sel_q), .sal_o(gate_w));
  assign bus.ack     = ack_q;
  assign bus.sal     = sal_q;
  assign bus.ocupado = st_q != LIBRE;
  assign bus.cuenta  = cuenta_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q     <= LIBRE;
      ptr_q    <= '0;
      idx_q    <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      ent_q    <= '0;
      sel_q    <= '0;
      res_q    <= 1'b0;
      sal_q    <= 1'b0;
      cuenta_q <= '0;
`ifdef ARBITRO_COMPUERTAS_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      ack_q <= '0;
      sal_q <= 1'b0;
      case (st_q)
        LIBRE: if (|bus.req) begin
          gnt_q <= gnt_w;
          idx_q <= idx_w;
          ent_q <= bus.ent[3*idx_w +: 3];
          sel_q <= bus.sel[3*idx_w +: 3];
          st_q  <= EVAL;
        end
        EVAL: begin
          res_q <= gate_w;
`ifdef ARBITRO_COMPUERTAS_ERR_EN
          err_q <= sel_invalido(sel_q);
`endif
          st_q  <= RESP;
        end
        RESP: begin
          ack_q <= gnt_q;
          sal_q <= res_q;
          ptr_q <= idx_q == IW'(N - 1) ? '0 : idx_q + 1'b1;
`ifdef ARBITRO_COMPUERTAS_ERR_EN
          err_q    <= 1'b0;
          cuenta_q <= err_q ? cuenta_q : cuenta_q + 1'b1;
`else
          cuenta_q <= cuenta_q + 1'b1;
`endif
          st_q  <= LIBRE;
        end
        default: st_q <= LIBRE;
      endcase
    end
endmodule

// File: tb/tb_arbitro_compuertas.sv
// tb_arbitro_compuertas: directed and random checks of arbitro_compuertas against a transaction model.
module tb_arbitro_compuertas;
  localparam int N  = 4;
  localparam int CW = 2;
`ifdef ARBITRO_COMPUERTAS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  arbitro_compuertas_if #(.N(N), .CNT_W(CW)) bus ();
  arbitro_compuertas #(.N(N), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_chk = 0;
  int n_err = 0;
  int m_busy = 0;
  int m_win = 0;
  int m_ptr = 0;
  int m_cuenta = 0;
  logic m_res = 1'b0;
  logic m_inv = 1'b0;
  logic m_sal = 1'b0;
  logic [N-1:0] m_ack = '0;
  bit hold = 1'b0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic gate(input logic [2:0] e, input logic [2:0] s);
    int ones;
    ones = int'(e[0]) + int'(e[1]) + int'(e[2]);
    case (s)
      3'd1: return ones == 3;
      3'd2: return ones > 0;
      3'd3: return ones % 2 == 1;
      3'd4: return ones < 3;
      3'd5: return ones == 0;
      3'd6: return ones % 2 == 0;
      default: return 1'b0;
    endcase
  endfunction
  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_cuenta = 0; m_ack = '0; m_sal = 1'b0; m_inv = 1'b0;
  endtask
  task automatic model_edge();
    logic [2:0] e, s;
    bit found;
    m_ack = '0;
    m_sal = 1'b0;
    if (m_busy == 2) begin
      m_ack[m_win] = 1'b1;
      m_sal = m_res;
      m_ptr = (m_win + 1) % N;
      if (!(ERR_EN && m_inv)) m_cuenta = (m_cuenta + 1) % (1 << CW);
      m_busy = 0;
    end else if (m_busy == 1) m_busy = 2;
    else if (bus.req != '0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++)
        if (!found && bus.req[(m_ptr + k) % N]) begin
          found = 1'b1;
          m_win = (m_ptr + k) % N;
        end
      e = bus.ent[3*m_win +: 3];
      s = bus.sel[3*m_win +: 3];
      m_res = gate(e, s);
      m_inv = s == 3'd0 || s == 3'd7;
      m_busy = 1;
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("ack", 32'(bus.ack), 32'(m_ack));
    check("sal", 32'(bus.sal), 32'(m_sal));
    check("ocupado", 32'(bus.ocupado), 32'(m_busy != 0));
    check("cuenta", 32'(bus.cuenta), 32'(m_cuenta));
`ifdef ARBITRO_COMPUERTAS_ERR_EN
    check("err", 32'(bus.err), 32'(m_busy == 2 && m_inv));
`endif
    if (!hold) bus.req = bus.req & ~bus.ack;
  endtask
  task automatic request(input int i, input logic [2:0] e, input logic [2:0] s);
    bus.ent[3*i +: 3] = e;
    bus.sel[3*i +: 3] = s;
    bus.req[i] = 1'b1;
  endtask
  initial begin
    int acks[$];
    int cnts[$];
    int when[$];
    int c0;
    bus.req = '0; bus.ent = '0; bus.sel = '0;
    #12;
    check("rst_ack", 32'(bus.ack), 0);
    check("rst_ocupado", 32'(bus.ocupado), 0);
    check("rst_cuenta", 32'(bus.cuenta), 0);
    rst_n = 1'b1;
    // Single AND on requester 2
    request(2, 3'b111, 3'b001);
    step(); step(); step();
    check("and_ack", 32'(bus.ack), 32'h4);
    check("and_sal", 32'(bus.sal), 1);
    check("and_cuenta", 32'(bus.cuenta), 1);
    // Operands changed during EVAL must not affect the result
    request(1, 3'b011, 3'b011);
    step();
    bus.ent[5:3] = 3'b001;
    step(); step();
    check("xor_ack", 32'(bus.ack), 32'h2);
    check("xor_sal", 32'(bus.sal), 0);
    // Invalid select
    c0 = int'(bus.cuenta);
    request(0, 3'b101, 3'b111);
    step(); step();
`ifdef ARBITRO_COMPUERTAS_ERR_EN
    check("inv_err", 32'(bus.err), 1);
`endif
    step();
    check("inv_sal", 32'(bus.sal), 0);
    check("inv_cuenta", 32'(bus.cuenta), ERR_EN ? 32'(c0) : 32'((c0 + 1) % 4));
    // Reset in the middle of EVAL
    request(3, 3'b000, 3'b101);
    step();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_ocupado", 32'(bus.ocupado), 0);
    check("mid_rst_ack", 32'(bus.ack), 0);
    check("mid_rst_cuenta", 32'(bus.cuenta), 0);
    bus.req = '0;
    #1 rst_n = 1'b1;
    step(); step(); step();
    // All four hold NOR requests; expect order 0,1,2,3,0 and counter wrap
    hold = 1'b1;
    for (int i = 0; i < N; i++) request(i, 3'b000, 3'b101);
    for (int c = 0; c < 16; c++) begin
      step();
      for (int i = 0; i < N; i++)
        if (bus.ack[i]) begin
          acks.push_back(i);
          cnts.push_back(int'(bus.cuenta));
          when.push_back(c);
          check("rr_sal", 32'(bus.sal), 1);
        end
    end
    check("rr_count", 32'(acks.size()), 5);
    for (int k = 0; k < 5 && k < acks.size(); k++) begin
      check("rr_order", 32'(acks[k]), 32'(k % N));
      check("rr_cuenta", 32'(cnts[k]), 32'((k + 1) % 4));
      if (k > 0) check("rr_spacing", 32'(when[k] - when[k-1]), 3);
    end
    hold = 1'b0;
    bus.req = '0;
    // Random traffic with operand churn and occasional early request drop
    for (int c = 0; c < 600; c++) begin
      step();
      bus.ent = 12'($urandom);
      bus.sel = 12'($urandom);
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i] && $urandom_range(3) == 0) bus.req[i] = 1'b1;
        else if (bus.req[i] && $urandom_range(60) == 0) bus.req[i] = 1'b0;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
